// File: rtl/nios_mul_pkg.sv
// nios_mul_pkg: op encodings and FSM states for the sequential 32x32 multiplier
package nios_mul_pkg;
    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXUU = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] OP_MULXSS = 2'd3;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_P3   = 3'd4,
        S_FIX  = 3'd5,
        S_DONE = 3'd6
    } state_t;
endpackage

// File: rtl/nios_mul_seq_pp.sv
// nios_mul_seq_pp: 16x16 unsigned partial-product multiplier with operand half-select
module nios_mul_seq_pp (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  half,
    output logic [31:0] p
);
    logic [15:0] x;
    logic [15:0] y;
    assign x = half[1] ? a[31:16] : a[15:0];
    assign y = half[0] ? b[31:16] : b[15:0];
    assign p = {16'd0, x} * {16'd0, y};
endmodule

// File: rtl/nios_mul_seq.sv
// nios_mul_seq: sequential 32x32 multiply accumulating 16x16 partials with signed high-word fix-up
module nios_mul_seq
    import nios_mul_pkg::*;
#(
    parameter bit SKIP_HI = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);
    state_t      state;
    state_t      p_next;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [63:0] acc;
    logic [63:0] acc_nxt;
    logic [31:0] pp;
    logic [31:0] corr;
    logic [31:0] res;
    logic [1:0]  half;
    logic [5:0]  sh;

    nios_mul_seq_pp u_pp (
        .a    (a),
        .b    (b),
        .half (half),
        .p    (pp)
    );

    assign in_ready = reset_n && state == S_IDLE;

    always_comb begin
        half    = state == S_P1 ? 2'b01 : state == S_P2 ? 2'b10 : state == S_P3 ? 2'b11 : 2'b00;
        sh      = state == S_P0 ? 6'd0 : state == S_P3 ? 6'd32 : 6'd16;
        corr    = (a[31] ? b : 32'd0) + ((op == OP_MULXSS && b[31]) ? a : 32'd0);
        acc_nxt = state == S_FIX ? {acc[63:32] - corr, acc[31:0]} : acc + ({32'd0, pp} << sh);
        res     = op == OP_MUL ? acc_nxt[31:0] : acc_nxt[63:32];
        p_next  = state == S_P0 ? S_P1 :
                  state == S_P1 ? S_P2 :
                  state == S_P2 ? ((op == OP_MUL && SKIP_HI) ? S_DONE : S_P3) :
                  state == S_P3 ? (op[1] ? S_FIX : S_DONE) : S_DONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            a          <= '0;
            b          <= '0;
            op         <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    a     <= in_a;
                    b     <= in_b;
                    op    <= in_op;
                    acc   <= '0;
                    busy  <= 1'b1;
                    state <= S_P0;
                end
                S_DONE: if (out_ready) begin
                    out_valid  <= 1'b0;
                    out_result <= '0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    acc   <= acc_nxt;
                    state <= p_next;
                    if (p_next == S_DONE) begin
                        out_valid  <= 1'b1;
                        out_result <= res;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nios_mul_seq.sv
// tb_nios_mul_seq: directed and random checks of nios_mul_seq for SKIP_HI=1 (index 0) and SKIP_HI=0 (index 1)
module tb_nios_mul_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [1:0]  in_op = '0;
    logic        in_valid [2];
    logic        out_ready [2];
    logic        in_ready [2];
    logic        out_valid [2];
    logic        busy [2];
    logic [31:0] out_result [2];
    int          n = 0;
    int          nbad = 0;

    always #5 clk = ~clk;

    nios_mul_seq #(.SKIP_HI(1'b1)) u0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_result(out_result[0]), .busy(busy[0])
    );
    nios_mul_seq #(.SKIP_HI(1'b0)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_result(out_result[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xe;
        logic [63:0] ye;
        logic [63:0] p;
        xe = {(o[1] ? {32{x[31]}} : 32'd0), x};
        ye = {((o == 2'd3) ? {32{y[31]}} : 32'd0), y};
        p  = xe * ye;
        return o == 2'd0 ? p[31:0] : p[63:32];
    endfunction

    function automatic int ref_lat(input int d, input logic [1:0] o);
        return o == 2'd0 ? (d == 0 ? 3 : 4) : o == 2'd1 ? 4 : 5;
    endfunction

    task automatic issue(input int d, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        in_a = x; in_b = y; in_op = o; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
        @(posedge clk);
        #1 in_valid[d] = 1'b0;
    endtask

    task automatic await_res(input int d, input bit noise, input string tag, input logic [31:0] r, input int lat);
        int k = 0;
        while (!out_valid[d] && k < 20) begin
            @(posedge clk);
            #1 k++;
            if (noise) begin
                in_valid[d] = 1'($urandom_range(0, 1));
                in_a = $urandom;
                in_b = $urandom;
            end
        end
        in_valid[d] = 1'b0;
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_res"}, out_result[d], r);
    endtask

    task automatic release_res(input int d);
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1 out_ready[d] = 1'b0;
    endtask

    task automatic run(input int d, input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] r, input int lat);
        issue(d, o, x, y);
        await_res(d, 1'b0, tag, r, lat);
        release_res(d);
        chk({tag, "_rdy"}, in_ready[d], 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_ready", in_ready[0], 1'b1);
        chk("rst_valid", out_valid[0], 1'b0);
        chk("rst_result", out_result[0], 32'h0);
        chk("rst_busy", busy[0], 1'b0);

        run(0, "mul_small", 2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3);
        run(0, "mulxuu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
        run(0, "mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3);
        run(0, "mulxss", 2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 5);
        run(0, "mulxsu", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5);
        run(1, "mul_ff_full", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4);
        run(1, "mulxuu_full", 2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 4);

        // backpressure: result and handshake state must hold while out_ready is low
        issue(0, 2'd0, 32'd1000, 32'd3000);
        await_res(0, 1'b0, "bp", 32'd3000000, 3);
        held = out_result[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid[0], 1'b1);
            chk("bp_hold", out_result[0], held);
            chk("bp_ready", in_ready[0], 1'b0);
        end
        release_res(0);
        chk("bp_rel_ready", in_ready[0], 1'b1);
        chk("bp_rel_valid", out_valid[0], 1'b0);
        chk("bp_rel_result", out_result[0], 32'h0);
        run(0, "bp_next", 2'd1, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 4);

        // reset during P2 of a MULXSS
        issue(0, 2'd3, 32'h1234_5678, 32'h8765_4321);
        repeat (2) @(posedge clk);
        #1;
        chk("p2_busy", busy[0], 1'b1);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid[0], 1'b0);
        chk("arst_result", out_result[0], 32'h0);
        chk("arst_busy", busy[0], 1'b0);
        chk("arst_ready", in_ready[0], 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("arst_rel_ready", in_ready[0], 1'b1);
        run(0, "post_rst", 2'd0, 32'd7, 32'd6, 32'h0000_002A, 3);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1000; i++) begin
                logic [1:0]  o;
                logic [31:0] x;
                logic [31:0] y;
                o = 2'($urandom_range(0, 3));
                x = $urandom;
                y = $urandom;
                if (i % 8 == 0) x = {1'b1, 31'($urandom_range(0, 3))};
                if (i % 8 == 1) y = 32'hFFFF_FFFF;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(d, o, x, y);
                await_res(d, 1'b1, "rnd", ref_mul(o, x, y), ref_lat(d, o));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                release_res(d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n, nbad);
        $finish;
    end
endmodule
